uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Memory-mapped transmit buffer between the NoobsCPU data bus and the UART `transmitter` serializer.
- The CPU writes bytes into a FIFO without polling per byte. A drain FSM pops bytes and hands them to the transmitter using its din/wr_en/tx_busy handshake.
- Replaces the direct single-register UART write path.
- Provides the read data and a hit flag for the SoC read-data mux.

Parameters:
- DATA_ADDR, 11'd101, bus address of TX data register (write = push, read = legacy busy bit)
- STAT_ADDR, 11'd102, bus address of status/control register
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16)

Ports:
- clk  in  1  block clock; bus and transmitter are both synchronous to it
- reset_  in  1  asynchronous active-low reset
- m_addr  in  11  CPU data address
- m_wr_data  in  8  CPU write data
- m_wr  in  1  CPU write strobe
- m_rd  in  1  CPU read strobe
- m_en  in  1  CPU data-bus enable
- rd_data  out  8  register read data, combinational from m_addr
- rd_hit  out  1  high when m_en & m_rd & m_addr is DATA_ADDR or STAT_ADDR
- tx_din  out  8  byte to transmitter
- tx_wr_en  out  1  one-cycle load pulse to transmitter
- tx_busy  in  1  transmitter busy
- fifo_empty  out  1  FIFO empty, registered
- overflow  out  1  sticky overflow flag

Behaviour:
- Reset (async on reset_ low), FIFO storage excepted:
  - rd/wr pointers = 0, count = 0
  - fifo_empty = 1, overflow = 0
  - tx_din = 0, tx_wr_en = 0, FSM = IDLE
  - Any byte in flight is abandoned; the FIFO is flushed.
- Bus write qualifier: wr_q = m_en & m_wr. It is sampled on posedge clk.
- Push: wr_q & m_addr==DATA_ADDR & count < DEPTH.
  - Stores m_wr_data at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1.
- Push when full: data is dropped, overflow <= 1, pointers unchanged.
- Write to STAT_ADDR with m_wr_data[7]=1:
  - Flushes the FIFO (pointers and count = 0).
  - Clears overflow.
  - Does not abort a byte already loaded into the transmitter.
- Read of STAT_ADDR returns:
  - bit0 empty, bit1 full, bit2 overflow, bit3 drain FSM busy (state != IDLE)
  - bits7:4 = count[3:0]; when count==16, bits7:4 read 0 and full=1
- Reads have no side effects.
- Read of DATA_ADDR returns {7'd0, full}. This is software-compatible with the legacy busy poll.
- rd_data = 0 when the address is not one of ours.
- Pointers are DEPTH_LOG2 bits wide. count is DEPTH_LOG2+1 bits. full = (count==DEPTH).
- Simultaneous push and pop in the same cycle:
  - Both happen; count is unchanged.
  - On a full FIFO with a pop, the push succeeds with no overflow, because the pop frees a slot in the same cycle.
- Drain FSM:
  - IDLE: if !empty & !tx_busy, pop the head, register tx_din <= head and tx_wr_en <= 1 next cycle, go LOAD.
  - LOAD: tx_wr_en is high for exactly this one cycle, then deasserts. Go WAIT_START.
  - WAIT_START: wait for tx_busy==1, then go WAIT_DONE. If tx_busy is not seen within 4 cycles, return to IDLE; this guards a transmitter that missed the strobe. The byte is not retried.
  - WAIT_DONE: wait for tx_busy==0, then go IDLE.
- Bus-to-line latency: a push into an empty FIFO with an idle transmitter gives tx_wr_en high 2 clk later (push edge -> IDLE sees !empty -> LOAD).
- Back-to-back gap: at least 1 IDLE cycle between tx_busy falling and the next tx_wr_en.
- tx_din holds its value until the next load.
- fifo_empty and overflow are registered copies of internal state.

Test Plan:
- Reset then idle: fifo_empty=1, overflow=0, tx_wr_en=0. STAT read returns 8'h01.
- Single byte 8'h48 to DATA_ADDR, transmitter model busy for 10 cycles after strobe:
  - tx_wr_en is a single pulse 2 cycles after the write, with tx_din=8'h48.
  - STAT bit3 stays high until busy falls.
  - Then STAT=8'h01.
- Burst of 17 writes (8'h00..8'h10) with tx_busy held high:
  - First byte is not popped.
  - count reaches 16, full=1.
  - 17th byte is dropped and overflow=1.
  - After busy is released, bytes 00..0F emerge in order; 8'h10 never appears.
- Push on the same cycle as a pop with count=16: count stays 16, overflow stays 0, the new byte appears last.
- STAT write 8'h80 with 5 queued bytes and one byte in flight:
  - count=0, overflow cleared.
  - In-flight byte completes; no further tx_wr_en.
- Reset asserted mid-WAIT_DONE with 3 queued: immediately tx_wr_en=0 and fifo_empty=1. After release, no strobe occurs.
- Transmitter never raises busy: FSM returns to IDLE after 4 cycles and the next queued byte is strobed.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Memory-mapped transmit buffer between the CPU data bus and the UART
// transmitter. The CPU pushes bytes into a FIFO. A drain FSM pops them one at a
// time and hands each to the transmitter with a single-cycle tx_wr_en strobe.
//
// Handshake to the transmitter: in LOAD, tx_din is stable and tx_wr_en is high
// for exactly one cycle. The transmitter acknowledges by raising tx_busy, and
// signals completion by dropping it. If busy is not seen within 4 cycles of
// LOAD, the byte is abandoned and the FSM returns to IDLE.
//
// Ports:
//   clk        block clock (bus and transmitter share it)
//   reset_     asynchronous active-low reset
//   m_addr     CPU data address
//   m_wr_data  CPU write data
//   m_wr       CPU write strobe
//   m_rd       CPU read strobe
//   m_en       CPU data-bus enable
//   rd_data    register read data, combinational from m_addr
//   rd_hit     high when a bus read targets DATA_ADDR or STAT_ADDR
//   tx_din     byte to the transmitter, held until the next load
//   tx_wr_en   one-cycle load pulse to the transmitter
//   tx_busy    transmitter busy
//   fifo_empty registered FIFO-empty flag
//   overflow   sticky flag: a push arrived while the FIFO was full
//   fsm_state  drain FSM state, for debug and checkers
//              (0 IDLE, 1 LOAD, 2 WAIT_START, 3 WAIT_DONE)
module uart_tx_fifo #(
  parameter logic [10:0] DATA_ADDR  = 11'd101,
  parameter logic [10:0] STAT_ADDR  = 11'd102,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [10:0] m_addr,
  input  logic [7:0]  m_wr_data,
  input  logic        m_wr,
  input  logic        m_rd,
  input  logic        m_en,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  output logic [7:0]  tx_din,
  output logic        tx_wr_en,
  input  logic        tx_busy,
  output logic        fifo_empty,
  output logic        overflow,
  output logic [1:0]  fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic [1:0]       wait_cnt;
  logic [1:0]       wait_cnt_d;
  state_t           state;
  state_t           state_d;

  logic wr_q;
  logic push_req;
  logic push_ok;
  logic overflow_set;
  logic flush;
  logic full;
  logic empty_i;
  logic pop;

  assign wr_q     = m_en & m_wr;
  assign push_req = wr_q & (m_addr == DATA_ADDR);
  assign flush    = wr_q & (m_addr == STAT_ADDR) & m_wr_data[7];
  assign full     = (count == CNT_FULL);
  assign empty_i  = (count == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still
  // lands when the drain FSM is popping.
  assign push_ok      = push_req & (~full | pop);
  assign overflow_set = push_req & full & ~pop;

  always_comb begin
    count_d = count;
    if (push_ok && !pop)      count_d = count + CNT_ONE;
    else if (pop && !push_ok) count_d = count - CNT_ONE;
  end

  // Drain FSM: next state and pop decision. A flush suppresses a new pop so
  // nothing from the discarded contents starts transmitting.
  always_comb begin
    state_d    = state;
    wait_cnt_d = 2'd0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty_i && !tx_busy && !flush) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (tx_busy)                state_d = ST_WAIT_DONE;
        else if (wait_cnt == 2'd3)  state_d = ST_IDLE;
        else                        wait_cnt_d = wait_cnt + 2'd1;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= ST_IDLE;
      wait_cnt   <= 2'd0;
      tx_wr_en   <= 1'b0;
      tx_din     <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      tx_wr_en <= (state_d == ST_LOAD);
      if (pop) tx_din <= mem[rd_ptr];

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        fifo_empty <= 1'b1;
        overflow   <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        count      <= count_d;
        fifo_empty <= (count_d == '0);
        if (overflow_set) overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= m_wr_data;
  end

  // Register reads. The count field is the low 4 bits, so a full FIFO reads
  // 0 there and is identified by the full bit instead.
  always_comb begin
    rd_data = 8'd0;
    if (m_addr == DATA_ADDR)
      rd_data = {7'd0, full};
    else if (m_addr == STAT_ADDR)
      rd_data = {4'(count), (state != ST_IDLE), overflow, full, fifo_empty};
  end

  assign rd_hit    = m_en & m_rd & ((m_addr == DATA_ADDR) | (m_addr == STAT_ADDR));
  assign fsm_state = state;

endmodule
